// File: rtl/param_lock_controller.sv
// param_lock_controller: parametrised keypad lock with password change, failed-try counting and timed lockout.
// Optional ENTRY_MASK_EN: in LOCKED, entered digits display as 0xA dashes instead of their values.
module param_lock_controller #(
    parameter int DIGITS         = 6,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int FLASH_DIV      = 50
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                key_valid,
    input  logic [3:0]          key_digit,
    input  logic                key_enter,
    input  logic                key_set,
    input  logic                key_lock,
    output logic [4*DIGITS-1:0] disp,
    output logic                unlocked,
    output logic                locked_out,
    output logic                led,
    output logic [3:0]          err_count,
    output logic                bad_key
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FW = $clog2(FLASH_DIV + 1);
`ifdef ENTRY_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_SET, S_LOCKOUT} state_t;

    state_t              r_state;
    logic [4*DIGITS-1:0] r_buf, r_pw;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_err;
    logic                r_led, r_bad;
    logic [TW-1:0]       r_timer;
    logic [FW-1:0]       r_flash;
    logic                w_full, w_match, w_dig_ok, w_flash_end;
    logic [3:0]          w_err_inc;
    logic [4*DIGITS-1:0] w_disp;

    assign w_full      = r_cnt == CW'(DIGITS);
    assign w_match     = w_full && r_buf == r_pw;
    assign w_dig_ok    = key_digit <= 4'd9 && !w_full;
    assign w_flash_end = r_flash == FW'(FLASH_DIV - 1);
    assign w_err_inc   = (r_err == 4'(MAX_TRIES)) ? r_err : r_err + 4'd1;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_LOCKED;
            r_buf   <= '0;
            r_pw    <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_led   <= 1'b0;
            r_bad   <= 1'b0;
            r_timer <= '0;
            r_flash <= '0;
        end else begin
            r_bad <= 1'b0;
            case (r_state)
                S_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state <= S_LOCKED;
                        r_err   <= '0;
                        r_led   <= 1'b0;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        r_flash <= w_flash_end ? '0 : r_flash + 1'b1;
                        if (w_flash_end) r_led <= ~r_led;
                    end
                end
                S_UNLOCKED: begin
                    if (key_lock) begin
                        r_state <= S_LOCKED;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end else if (key_set && !key_enter) begin
                        r_state <= S_SET;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (key_lock) begin
                        r_state <= S_LOCKED;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end else if (key_enter) begin
                        if (r_state == S_SET && !w_full) r_bad <= 1'b1;
                        else begin
                            r_buf <= '0;
                            r_cnt <= '0;
                            if (r_state == S_SET) begin
                                r_pw    <= r_buf;
                                r_state <= S_UNLOCKED;
                            end else if (w_match) begin
                                r_state <= S_UNLOCKED;
                                r_err   <= '0;
                            end else begin
                                r_bad <= 1'b1;
                                r_err <= w_err_inc;
                                if (w_err_inc == 4'(MAX_TRIES)) begin
                                    r_state <= S_LOCKOUT;
                                    r_timer <= TW'(LOCKOUT_CYCLES - 1);
                                    r_flash <= '0;
                                    r_led   <= 1'b1;
                                end
                            end
                        end
                    end else if (!key_set && key_valid) begin
                        if (w_dig_ok) begin
                            r_buf[4*(DIGITS-1-int'(r_cnt)) +: 4] <= key_digit;
                            r_cnt <= r_cnt + 1'b1;
                        end else r_bad <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Display is a pure decode of registered state, so it moves one cycle after the strobe.
    always_comb begin
        w_disp = '0;
        for (int i = 0; i < DIGITS; i++)
            w_disp[4*(DIGITS-1-i) +: 4] = (r_state == S_UNLOCKED) ? 4'h0 :
                                          (r_state == S_LOCKOUT)  ? 4'hE :
                                          (i < int'(r_cnt)) ? ((MASK && r_state == S_LOCKED) ? 4'hA : r_buf[4*(DIGITS-1-i) +: 4]) :
                                          4'hF;
    end

    assign disp       = w_disp;
    assign unlocked   = r_state == S_UNLOCKED || r_state == S_SET;
    assign locked_out = r_state == S_LOCKOUT;
    assign led        = r_led;
    assign err_count  = r_err;
    assign bad_key    = r_bad;
endmodule

// File: tb/tb_param_lock_controller.sv
// tb_param_lock_controller: directed checks of entry, unlock, password change, lockout and reset.
module tb_param_lock_controller;
    logic        clk = 1'b0, clr = 1'b1;
    logic        key_valid = 1'b0, key_enter = 1'b0, key_set = 1'b0, key_lock = 1'b0;
    logic [3:0]  key_digit = 4'h0;
    logic [23:0] disp;
    logic        unlocked, locked_out, led, bad_key;
    logic [3:0]  err_count;
    int          total = 0, bad = 0;

    param_lock_controller #(.DIGITS(6), .MAX_TRIES(3), .LOCKOUT_CYCLES(20), .FLASH_DIV(4)) dut (
        .clk(clk), .clr(clr), .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
        .key_set(key_set), .key_lock(key_lock), .disp(disp), .unlocked(unlocked),
        .locked_out(locked_out), .led(led), .err_count(err_count), .bad_key(bad_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic lock();
        key_lock = 1'b1;
        tick();
        key_lock = 1'b0;
    endtask

    task automatic setk();
        key_set = 1'b1;
        tick();
        key_set = 1'b0;
    endtask

    task automatic code(input logic [23:0] c);
        for (int i = 0; i < 6; i++) key(c[23-4*i -: 4]);
        enter();
    endtask

    initial begin
        tick();
        tick();
        clr = 1'b0;
        chk("rst_disp", disp, 32'hFFFFFF);
        chk("rst_unl", unlocked, 0);
        chk("rst_lo", locked_out, 0);
        chk("rst_led", led, 0);
        chk("rst_err", err_count, 0);
        chk("rst_bad", bad_key, 0);
        key(0); key(0); key(0);
        chk("part_disp", disp, 32'h000FFF);
        key(0); key(0); key(0);
        enter();
        chk("open0_unl", unlocked, 1);
        chk("open0_disp", disp, 32'h000000);
        chk("open0_err", err_count, 0);
        setk();
        chk("set_unl", unlocked, 1);
        chk("set_disp", disp, 32'hFFFFFF);
        for (int i = 1; i <= 6; i++) key(4'(i));
        chk("set_digits", disp, 32'h123456);
        enter();
        chk("set_done_unl", unlocked, 1);
        chk("set_done_disp", disp, 32'h000000);
        lock();
        chk("relock_unl", unlocked, 0);
        chk("relock_disp", disp, 32'hFFFFFF);
        code(24'h123456);
        chk("newpw_unl", unlocked, 1);
        lock();
        code(24'h111111);
        chk("w1_err", err_count, 1);
        chk("w1_bad", bad_key, 1);
        chk("w1_disp", disp, 32'hFFFFFF);
        tick();
        chk("w1_bad_end", bad_key, 0);
        code(24'h222222);
        chk("w2_err", err_count, 2);
        code(24'h654321);
        chk("w3_err", err_count, 3);
        chk("w3_lo", locked_out, 1);
        chk("w3_disp", disp, 32'hEEEEEE);
        chk("w3_led", led, 1);
        repeat (3) tick();
        chk("led_hold", led, 1);
        tick();
        chk("led_toggle", led, 0);
        key(5);
        chk("lo_key_bad", bad_key, 0);
        chk("lo_key_disp", disp, 32'hEEEEEE);
        repeat (3) tick();
        chk("led_toggle2", led, 1);
        repeat (11) tick();
        chk("lo_still", locked_out, 1);
        tick();
        chk("lo_end", locked_out, 0);
        chk("lo_end_err", err_count, 0);
        chk("lo_end_led", led, 0);
        chk("lo_end_disp", disp, 32'hFFFFFF);
        key(1); key(2);
        key(4'hB);
        chk("badkey_bad", bad_key, 1);
        chk("badkey_disp", disp, 32'h12FFFF);
        key(3); key(4); key(5); key(6);
        key(7);
        chk("overflow_bad", bad_key, 1);
        chk("overflow_disp", disp, 32'h123456);
        lock();
        chk("abort_disp", disp, 32'hFFFFFF);
        for (int i = 1; i <= 5; i++) key(4'(i));
        enter();
        chk("short_bad", bad_key, 1);
        chk("short_err", err_count, 1);
        chk("short_disp", disp, 32'hFFFFFF);
        for (int i = 1; i <= 6; i++) key(4'(i));
        key_enter = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
        tick();
        key_enter = 1'b0; key_valid = 1'b0;
        chk("prio_unl", unlocked, 1);
        chk("prio_err", err_count, 0);
        chk("prio_disp", disp, 32'h000000);
        setk();
        key(1); key(2);
        enter();
        chk("set_short_bad", bad_key, 1);
        chk("set_short_disp", disp, 32'h12FFFF);
        key(9); key(9); key(9); key(9);
        chk("set_full_disp", disp, 32'h129999);
        key_lock = 1'b1; key_enter = 1'b1;
        tick();
        key_lock = 1'b0; key_enter = 1'b0;
        chk("abort_set_unl", unlocked, 0);
        chk("abort_set_disp", disp, 32'hFFFFFF);
        code(24'h129999);
        chk("old_pw_kept_wrong", unlocked, 0);
        code(24'h123456);
        chk("old_pw_kept", unlocked, 1);
        lock();
        key(1); key(2); key(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_mid_disp", disp, 32'hFFFFFF);
        chk("clr_mid_err", err_count, 0);
        chk("clr_mid_unl", unlocked, 0);
        code(24'h000000);
        chk("clr_mid_pw", unlocked, 1);
        lock();
        code(24'h111111); code(24'h111111); code(24'h111111);
        chk("lo2_lo", locked_out, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_lo_lo", locked_out, 0);
        chk("clr_lo_led", led, 0);
        chk("clr_lo_err", err_count, 0);
        chk("clr_lo_bad", bad_key, 0);
        chk("clr_lo_disp", disp, 32'hFFFFFF);
        code(24'h000000);
        chk("clr_lo_pw", unlocked, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_lock_controller.md
Name: param_lock_controller

Overview:
- Parametrised successor to the six-digit lock controller.
- Digit-serial keypad entry of a DIGITS-long BCD code, stored-password compare, and password change permitted only while unlocked.
- Counts failed attempts and enters a timed lockout with a flashing LED after MAX_TRIES failures.
- Sits between the keypad debouncer and the seven-segment/LED drivers.

Parameters:
- DIGITS, 6, number of BCD digits in password and entry buffer (2..16).
- MAX_TRIES, 3, consecutive failed verifies that trigger lockout (1..15).
- LOCKOUT_CYCLES, 1000, clk cycles spent in LOCKOUT.
- FLASH_DIV, 50, clk cycles per LED half-period during lockout.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit holds a new digit.
- key_digit  in  4  BCD digit; values 10..15 are invalid.
- key_enter  in  1  one-cycle strobe: submit buffer.
- key_set  in  1  one-cycle strobe: request password change (UNLOCKED only).
- key_lock  in  1  one-cycle strobe: relock / abort set.
- disp  out  4*DIGITS  display nibbles; digit 0 (first entered) in MSBs.
- unlocked  out  1  high in UNLOCKED and SET.
- locked_out  out  1  high in LOCKOUT.
- led  out  1  flashing lockout indicator.
- err_count  out  4  consecutive failed attempts.
- bad_key  out  1  one-cycle pulse on a rejected key or enter.

Behaviour:
- Reset (clr=1 at a clk edge, any state, mid-entry included):
  - state=LOCKED; password=all 0; buffer cleared; cnt=0.
  - err_count=0; led=0; timers=0; bad_key=0.
  - disp=all 0xF (blank).
- States: LOCKED, UNLOCKED, SET, LOCKOUT. All outputs registered; state and output change one cycle after the strobe edge.
- Digit entry (LOCKED and SET):
  - key_valid with key_digit<=9 and cnt<DIGITS: buffer[cnt]<=digit, cnt++.
  - Invalid digit, or cnt==DIGITS: digit discarded, bad_key pulse.
- Strobe priority within a cycle: key_lock > key_enter > key_set > key_valid. Lower-priority strobes in the same cycle are discarded silently.
- LOCKED, key_enter:
  - cnt==DIGITS and buffer==password: go to UNLOCKED, err_count<=0.
  - Otherwise: err_count++, bad_key pulse, buffer and cnt cleared.
  - If the incremented err_count==MAX_TRIES: go to LOCKOUT, lockout timer<=LOCKOUT_CYCLES-1, flash counter<=0, led<=1.
- LOCKED, key_set: ignored (no pulse). key_lock: clears buffer and cnt.
- UNLOCKED:
  - key_set: go to SET with buffer and cnt cleared.
  - key_lock: go to LOCKED with buffer cleared.
  - key_valid and key_enter: ignored.
- SET:
  - key_enter with cnt==DIGITS: password<=buffer, go to UNLOCKED, buffer cleared.
  - key_enter with cnt<DIGITS: bad_key pulse, stay in SET, buffer kept.
  - key_lock: go to LOCKED, password unchanged.
- LOCKOUT:
  - All key inputs ignored.
  - Timer decrements every cycle; led toggles each time the flash counter reaches FLASH_DIV-1, after which the counter wraps to 0.
  - When timer==0: go to LOCKED, err_count<=0, led<=0, buffer cleared.
- disp:
  - LOCKED/SET: buffer[i] for i<cnt, 0xF for unfilled positions.
  - UNLOCKED: all 0x0.
  - LOCKOUT: all 0xE.
- err_count saturates at MAX_TRIES and never wraps.

Optional Feature:
- Macro ENTRY_MASK_EN.
- Defined: in LOCKED, filled positions show 0xA (dash) instead of the digit; SET still shows real digits.
- Undefined: filled positions show the digit value in all entry states.

Test Plan (DIGITS=6, MAX_TRIES=3, LOCKOUT_CYCLES=20, FLASH_DIV=4, macro undefined):
- Reset, then keys 0,0,0,0,0,0 and enter -> unlocked=1 next cycle, disp=0x000000, err_count=0.
- From UNLOCKED: key_set, keys 1,2,3,4,5,6, enter -> unlocked=1, then key_lock -> unlocked=0. Keys 1..6 and enter -> unlocked=1.
- Three wrong 6-digit codes (password 123456) -> err_count 1,2,3. After the third enter, locked_out=1 and disp=0xEEEEEE. led toggles every 4 cycles. After exactly 20 cycles: locked_out=0, err_count=0, led=0.
- Key 0xB in LOCKED -> bad_key pulse, cnt unchanged. Seventh digit -> bad_key pulse. Enter after 5 digits -> bad_key, err_count+1, disp=0xFFFFFF.
- key_enter and key_valid(7) in the same cycle with a correct full buffer -> UNLOCKED, digit 7 not stored. key_lock with key_enter in SET -> LOCKED, password unchanged.
- clr asserted mid-entry after 3 digits, and again during LOCKOUT -> next cycle all outputs at reset values, password 000000 accepted.
